// File: rtl/memory_access_unit.sv
// memory_access_unit: turns byte-granular core loads/stores into naturally-aligned bus
// transactions with lane enables, and extends load results back to the core.
module memory_access_unit #(
    parameter int DATA_SIZE = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   core_rd_en,
    input  logic                   core_wr_en,
    input  logic [DATA_SIZE-1:0]   core_addr,
    input  logic [DATA_SIZE-1:0]   core_wr_data,
    input  logic [2:0]             core_funct3,
    output logic [DATA_SIZE-1:0]   core_rd_data,
    output logic                   core_done,
    output logic                   core_busy,
    output logic                   misaligned_load,
    output logic                   misaligned_store,
    output logic [DATA_SIZE-1:0]   mem_addr,
    output logic [DATA_SIZE-1:0]   mem_wr_data,
    output logic [DATA_SIZE/8-1:0] mem_byte_en,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    input  logic [DATA_SIZE-1:0]   mem_rd_data,
    input  logic                   mem_ack
);
    localparam int BYTES = DATA_SIZE / 8;
    localparam int OW = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;

    state_t                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [OW-1:0]         offset_q, offset_d;
    logic [DATA_SIZE-1:0]  rd_data_q, rd_data_d;
    logic [DATA_SIZE-1:0]  addr_q, addr_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
    logic [BYTES-1:0]      be_q, be_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  mis_ld_q, mis_ld_d;
    logic                  mis_st_q, mis_st_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;

    logic                  misaligned;
    logic [1:0]            size_code;
    logic [BYTES-1:0]      lane_mask;
    logic [7:0]            pad;
    logic [DATA_SIZE-1:0]  shifted, up, ext;
    logic signed [DATA_SIZE-1:0] sext;

    always_comb begin
        size_code = core_funct3[1:0];
        misaligned = core_funct3 == 3'b111
                  || (DATA_SIZE == 32 && (size_code == 2'b11 || core_funct3 == 3'b110))
                  || (core_addr[2:0] & ((3'd1 << size_code) - 3'd1)) != 3'd0;
        lane_mask = ~({BYTES{1'b1}} << (4'd1 << size_code));
        // Move the lane down to bit 0, then push it to the top so one right shift extends it
        shifted = mem_rd_data >> {offset_q, 3'b000};
        pad = 8'(DATA_SIZE) - (8'd8 << funct3_q[1:0]);
        up = shifted << pad;
        sext = $signed(up) >>> pad;
        ext = funct3_q[2] ? up >> pad : sext;
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        offset_d   = offset_q;
        rd_data_d  = rd_data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        done_d     = 1'b0;
        mis_ld_d   = 1'b0;
        mis_st_d   = 1'b0;
        case (state_q)
            IDLE: if (core_wr_en || core_rd_en) begin
                is_store_d = core_wr_en;
                funct3_d   = core_funct3;
                if (misaligned) begin
                    state_d  = FAULT;
                    done_d   = 1'b1;
                    mis_st_d = core_wr_en;
                    mis_ld_d = !core_wr_en;
                end else begin
                    state_d  = BUSY;
                    offset_d = core_addr[OW-1:0];
                    addr_d   = {core_addr[DATA_SIZE-1:OW], {OW{1'b0}}};
                    be_d     = lane_mask << core_addr[OW-1:0];
                    wdata_d  = core_wr_data << {core_addr[OW-1:0], 3'b000};
                    rd_en_d  = !core_wr_en;
                    wr_en_d  = core_wr_en;
                end
            end
            BUSY: if (mem_ack) begin
                state_d   = DONE;
                done_d    = 1'b1;
                rd_en_d   = 1'b0;
                wr_en_d   = 1'b0;
                rd_data_d = is_store_q ? rd_data_q : ext;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            offset_q   <= '0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mis_ld_q   <= 1'b0;
            mis_st_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
            rd_data_q  <= rd_data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            mis_ld_q   <= mis_ld_d;
            mis_st_q   <= mis_st_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign core_rd_data     = rd_data_q;
    assign core_done        = done_q;
    assign core_busy        = busy_q;
    assign misaligned_load  = mis_ld_q;
    assign misaligned_store = mis_st_q;
    assign mem_addr         = addr_q;
    assign mem_wr_data      = wdata_q;
    assign mem_byte_en      = be_q;
    assign mem_rd_en        = rd_en_q;
    assign mem_wr_en        = wr_en_q;
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed vector table plus hand sequences on 32- and 64-bit instances.
module tb_memory_access_unit;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        rd, wr, done, busy, mld, mst, mrd, mwr, mack;
    logic [31:0] addr, wdata, rdo, maddr, mwdata, mrdata;
    logic [2:0]  f3;
    logic [3:0]  be;

    logic        rd6, wr6, done6, busy6, mld6, mst6, mrd6, mwr6, mack6;
    logic [63:0] addr6, wdata6, rdo6, maddr6, mwdata6, mrdata6;
    logic [2:0]  f36;
    logic [7:0]  be6;

    memory_access_unit #(.DATA_SIZE(32)) dut32 (
        .clock(clock), .reset(reset), .core_rd_en(rd), .core_wr_en(wr), .core_addr(addr),
        .core_wr_data(wdata), .core_funct3(f3), .core_rd_data(rdo), .core_done(done),
        .core_busy(busy), .misaligned_load(mld), .misaligned_store(mst), .mem_addr(maddr),
        .mem_wr_data(mwdata), .mem_byte_en(be), .mem_rd_en(mrd), .mem_wr_en(mwr),
        .mem_rd_data(mrdata), .mem_ack(mack)
    );

    memory_access_unit #(.DATA_SIZE(64)) dut64 (
        .clock(clock), .reset(reset), .core_rd_en(rd6), .core_wr_en(wr6), .core_addr(addr6),
        .core_wr_data(wdata6), .core_funct3(f36), .core_rd_data(rdo6), .core_done(done6),
        .core_busy(busy6), .misaligned_load(mld6), .misaligned_store(mst6), .mem_addr(maddr6),
        .mem_wr_data(mwdata6), .mem_byte_en(be6), .mem_rd_en(mrd6), .mem_wr_en(mwr6),
        .mem_rd_data(mrdata6), .mem_ack(mack6)
    );

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          delay;
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [15];

    task automatic run32(input vec_t v, input string t);
        @(negedge clock);
        rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata; f3 = v.f3;
        @(negedge clock);
        rd = 1'b0; wr = 1'b0;
        if (v.fault) begin
            chk({t, " fault done"}, 64'(done), 64'(1));
            chk({t, " mis_ld"}, 64'(mld), 64'(!v.wr));
            chk({t, " mis_st"}, 64'(mst), 64'(v.wr));
            chk({t, " fault rd_en"}, 64'(mrd), 64'(0));
            chk({t, " fault wr_en"}, 64'(mwr), 64'(0));
            chk({t, " fault busy"}, 64'(busy), 64'(1));
            @(negedge clock);
            chk({t, " fault done drop"}, 64'(done), 64'(0));
            chk({t, " fault mis drop"}, 64'({mld, mst}), 64'(0));
            chk({t, " fault idle"}, 64'(busy), 64'(0));
        end else begin
            for (int i = 1; i <= v.delay; i++) begin
                chk($sformatf("%s rd_en c%0d", t, i), 64'(mrd), 64'(v.rd && !v.wr));
                chk($sformatf("%s wr_en c%0d", t, i), 64'(mwr), 64'(v.wr));
                chk($sformatf("%s addr c%0d", t, i), 64'(maddr), 64'(v.exp_addr));
                chk($sformatf("%s be c%0d", t, i), 64'(be), 64'(v.exp_be));
                chk($sformatf("%s early done c%0d", t, i), 64'(done), 64'(0));
                if (v.wr) chk($sformatf("%s wdata c%0d", t, i), 64'(mwdata), 64'(v.exp_wdata));
                if (i == v.delay) begin
                    mack = 1'b1;
                    mrdata = v.rdata;
                end
                @(negedge clock);
                mack = 1'b0;
            end
            chk({t, " done"}, 64'(done), 64'(1));
            chk({t, " rd_data"}, 64'(rdo), 64'(v.exp_rd));
            chk({t, " en drop"}, 64'({mrd, mwr}), 64'(0));
            chk({t, " no fault"}, 64'({mld, mst}), 64'(0));
            @(negedge clock);
            chk({t, " done drop"}, 64'(done), 64'(0));
            chk({t, " idle"}, 64'(busy), 64'(0));
        end
    endtask

    task automatic run64(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [2:0] f, input logic [63:0] rdat, input logic fault,
                         input logic [63:0] ea, input logic [7:0] eb, input logic [63:0] er,
                         input string t);
        @(negedge clock);
        rd6 = r; wr6 = w; addr6 = a; wdata6 = d; f36 = f;
        @(negedge clock);
        rd6 = 1'b0; wr6 = 1'b0;
        if (fault) begin
            chk({t, " done"}, 64'(done6), 64'(1));
            chk({t, " mis_ld"}, 64'(mld6), 64'(!w));
            chk({t, " mis_st"}, 64'(mst6), 64'(w));
            chk({t, " no bus"}, 64'({mrd6, mwr6}), 64'(0));
            @(negedge clock);
        end else begin
            chk({t, " rd_en"}, 64'(mrd6), 64'(r && !w));
            chk({t, " wr_en"}, 64'(mwr6), 64'(w));
            chk({t, " addr"}, maddr6, ea);
            chk({t, " be"}, 64'(be6), 64'(eb));
            if (w) chk({t, " wdata"}, mwdata6, d);
            mack6 = 1'b1;
            mrdata6 = rdat;
            @(negedge clock);
            mack6 = 1'b0;
            chk({t, " done"}, 64'(done6), 64'(1));
            chk({t, " rd_data"}, rdo6, er);
            @(negedge clock);
            chk({t, " done drop"}, 64'(done6), 64'(0));
        end
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b1, 32'h1003, 32'h000000A5, 3'b000, 3, 32'hFFFFFFFF, 1'b0, 32'h1000, 4'b1000, 32'hA5000000, 32'h00000000};
        vt[1]  = '{1'b1, 1'b0, 32'h2002, 32'h0, 3'b001, 1, 32'h80011234, 1'b0, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001};
        vt[2]  = '{1'b1, 1'b0, 32'h2002, 32'h0, 3'b101, 2, 32'h80011234, 1'b0, 32'h2000, 4'b1100, 32'h0, 32'h00008001};
        vt[3]  = '{1'b0, 1'b1, 32'h0010, 32'hDEADBEEF, 3'b010, 1, 32'hFFFFFFFF, 1'b0, 32'h0010, 4'b1111, 32'hDEADBEEF, 32'h00008001};
        vt[4]  = '{1'b1, 1'b0, 32'h5001, 32'h0, 3'b000, 1, 32'h00008000, 1'b0, 32'h5000, 4'b0010, 32'h0, 32'hFFFFFF80};
        vt[5]  = '{1'b1, 1'b0, 32'h5003, 32'h0, 3'b100, 2, 32'h7F000000, 1'b0, 32'h5000, 4'b1000, 32'h0, 32'h0000007F};
        vt[6]  = '{1'b1, 1'b0, 32'h6000, 32'h0, 3'b010, 1, 32'h89ABCDEF, 1'b0, 32'h6000, 4'b1111, 32'h0, 32'h89ABCDEF};
        vt[7]  = '{1'b1, 1'b0, 32'h3001, 32'h0, 3'b010, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 32'h3002, 32'h1, 3'b010, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 32'h3001, 32'h0, 3'b001, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        vt[10] = '{1'b1, 1'b0, 32'h0000, 32'h0, 3'b011, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        vt[11] = '{1'b1, 1'b0, 32'h0000, 32'h0, 3'b111, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        vt[12] = '{1'b1, 1'b1, 32'h4000, 32'h11223344, 3'b010, 2, 32'hFFFFFFFF, 1'b0, 32'h4000, 4'b1111, 32'h11223344, 32'h89ABCDEF};
        vt[13] = '{1'b0, 1'b1, 32'h4006, 32'h0000BEEF, 3'b001, 1, 32'hFFFFFFFF, 1'b0, 32'h4004, 4'b1100, 32'hBEEF0000, 32'h89ABCDEF};
        vt[14] = '{1'b1, 1'b0, 32'h0000, 32'h0, 3'b110, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};

        reset = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; f3 = '0; mrdata = '0; mack = 1'b0;
        rd6 = 1'b0; wr6 = 1'b0; addr6 = '0; wdata6 = '0; f36 = '0; mrdata6 = '0; mack6 = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset outputs32", {rdo, maddr}, 64'(0));
        chk("reset bus32", {mwdata, 28'(0), be}, 64'(0));
        chk("reset strobes32", 64'({done, busy, mld, mst, mrd, mwr}), 64'(0));
        chk("reset rd_data64", rdo6, 64'(0));
        chk("reset bus64", maddr6 | mwdata6 | 64'(be6), 64'(0));
        chk("reset strobes64", 64'({done6, busy6, mld6, mst6, mrd6, mwr6}), 64'(0));
        reset = 1'b1;

        for (int k = 0; k < 15; k++) run32(vt[k], $sformatf("v%0d", k));

        // mem_ack tied high: minimum latency and back-to-back acceptance
        @(negedge clock);
        rd = 1'b1; addr = 32'h7000; f3 = 3'b010; mack = 1'b1; mrdata = 32'h12345678;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            chk($sformatf("b2b done c%0d", c), 64'(done), 64'(c == 2 || c == 5));
            chk($sformatf("b2b rd_en c%0d", c), 64'(mrd), 64'(c == 1 || c == 4));
            chk($sformatf("b2b busy c%0d", c), 64'(busy), 64'(c != 3 && c != 6));
            if (c == 5) chk("b2b rd_data", 64'(rdo), 64'(32'h12345678));
        end
        rd = 1'b0; mack = 1'b0;

        // reset in the middle of an unacknowledged load
        @(negedge clock);
        rd = 1'b1; addr = 32'h8000; f3 = 3'b010;
        @(negedge clock);
        rd = 1'b0;
        chk("rst busy rd_en", 64'(mrd), 64'(1));
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("rst rd_en", 64'(mrd), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst rd_data", 64'(rdo), 64'(0));
        chk("rst addr", 64'(maddr), 64'(0));
        mack = 1'b1;
        @(negedge clock);
        mack = 1'b0;
        chk("late ack done", 64'(done), 64'(0));
        chk("late ack busy", 64'(busy), 64'(0));
        @(negedge clock);
        chk("late ack done2", 64'(done), 64'(0));
        run32('{1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 1, 32'h000000FF, 1'b0, 32'h0, 4'b0001, 32'h0, 32'hFFFFFFFF}, "lb after rst");

        run64(1'b1, 1'b0, 64'h1004, 64'h0, 3'b110, 64'h8000000000000000, 1'b0, 64'h1000, 8'hF0, 64'h0000000080000000, "lwu64");
        run64(1'b1, 1'b0, 64'h1004, 64'h0, 3'b010, 64'h8000000000000000, 1'b0, 64'h1000, 8'hF0, 64'hFFFFFFFF80000000, "lw64");
        run64(1'b1, 1'b0, 64'h1004, 64'h0, 3'b011, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, "ld64 mis");
        run64(1'b0, 1'b1, 64'h1008, 64'h0123456789ABCDEF, 3'b011, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h1008, 8'hFF, 64'hFFFFFFFF80000000, "sd64");
        run64(1'b1, 1'b0, 64'h0010, 64'h0, 3'b011, 64'hFEDCBA9876543210, 1'b0, 64'h0010, 8'hFF, 64'hFEDCBA9876543210, "ld64");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
